// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch stage: issues word fetches over req/ack,
// buffers one instruction for decode and kills wrong-path fetches on branch redirect.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    BUSY  = 2'd2,
    KILL  = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] if_instr_reg, if_instr_next;
  logic [31:0] if_pc_reg, if_pc_next;
  logic        if_valid_reg, if_valid_next;

  logic        issue_ok;
  logic        req;
  logic        capture;
  logic        redirect;
  logic [31:0] cur_addr;

  // A new request may go out only if decode can absorb the result next cycle.
  assign issue_ok = !stall && (!if_valid_reg || if_ready);
  assign redirect = branch_taken && (state_reg != IDLE);

  // While a request is outstanding the address comes from the latch, not the PC.
  assign cur_addr = ((state_reg == BUSY) || (state_reg == KILL)) ? addr_reg : pc_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      pc_reg       <= RESET_PC;
      addr_reg     <= RESET_PC;
      if_valid_reg <= 1'b0;
      if_instr_reg <= 32'h0;
      if_pc_reg    <= 32'h0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      addr_reg     <= addr_next;
      if_valid_reg <= if_valid_next;
      if_instr_reg <= if_instr_next;
      if_pc_reg    <= if_pc_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    req        = 1'b0;
    capture    = 1'b0;

    case (state_reg)
      IDLE: begin
        state_next = FETCH;
      end
      FETCH: begin
        req = issue_ok;
        if (req && !imem_ack) begin
          addr_next  = pc_reg;
          state_next = branch_taken ? KILL : BUSY;
        end else if (req && imem_ack && !branch_taken) begin
          capture = 1'b1;
        end
      end
      BUSY: begin
        req = 1'b1;
        if (imem_ack) begin
          state_next = FETCH;
          capture    = !branch_taken;
        end else if (branch_taken) begin
          state_next = KILL;
        end
      end
      KILL: begin
        req = 1'b1;
        if (imem_ack) begin
          state_next = FETCH;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    pc_next       = pc_reg;
    if_valid_next = if_valid_reg;
    if_instr_next = if_instr_reg;
    if_pc_next    = if_pc_reg;

    if (capture) begin
      pc_next       = cur_addr + STEP;
      if_valid_next = 1'b1;
      if_instr_next = imem_rdata;
      if_pc_next    = cur_addr;
    end else if (if_valid_reg && if_ready) begin
      if_valid_next = 1'b0;
    end

    // Redirect overrides everything: wrong-path instruction is flushed regardless of ready.
    if (redirect) begin
      pc_next       = branch_target & ~32'h3;
      if_valid_next = 1'b0;
    end
  end

  assign imem_req  = req;
  assign imem_addr = cur_addr;
  assign if_valid  = if_valid_reg;
  assign if_instr  = if_instr_reg;
  assign if_pc     = if_pc_reg;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit; memory returns addr ^ 32'hDEAD_0000 as the instruction.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  int vectors = 0;
  int miscompares = 0;

  pc_fetch_unit #(.RESET_PC(32'h0000_0100), .PC_STEP(4)) dut (
    .clk(clk), .rst_n(rst_n), .branch_taken(branch_taken), .branch_target(branch_target),
    .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc)
  );

  always #5 clk = ~clk;
  assign imem_rdata = imem_addr ^ 32'hDEAD_0000;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    stall = 1'b0; imem_ack = 1'b0; if_ready = 1'b0;
    step(); step();
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_req",   32'(imem_req), 32'd0);
    check("rst_addr",  imem_addr, 32'h0000_0100);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_instr", if_instr, 32'h0);

    // T1: ack tied high, decode always ready
    imem_ack = 1'b1; if_ready = 1'b1; rst_n = 1'b1;
    step();
    check("t1_valid_e1", 32'(if_valid), 32'd0);
    check("t1_req",      32'(imem_req), 32'd1);
    check("t1_addr",     imem_addr, 32'h0000_0100);
    step();
    check("t1_valid_e2", 32'(if_valid), 32'd1);
    check("t1_pc0",      if_pc, 32'h0000_0100);
    check("t1_instr0",   if_instr, 32'hDEAD_0100);
    step();
    check("t1_pc1",      if_pc, 32'h0000_0104);
    step();
    check("t1_pc2",      if_pc, 32'h0000_0108);

    // T2: backpressure freezes buffer and blocks requests
    if_ready = 1'b0;
    #1;
    check("t2_req_off", 32'(imem_req), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("t2_hold_pc",    if_pc, 32'h0000_0108);
      check("t2_hold_instr", if_instr, 32'hDEAD_0108);
      check("t2_hold_req",   32'(imem_req), 32'd0);
    end
    if_ready = 1'b1;
    #1;
    check("t2_req_on", 32'(imem_req), 32'd1);
    check("t2_addr",   imem_addr, 32'h0000_010C);
    step();
    check("t2_next_pc",    if_pc, 32'h0000_010C);
    check("t2_next_valid", 32'(if_valid), 32'd1);

    // T3: redirect to 0x200 with same-cycle ack, then slow memory
    branch_taken = 1'b1; branch_target = 32'h0000_0200;
    step();
    check("t3_flush", 32'(if_valid), 32'd0);
    branch_taken = 1'b0; imem_ack = 1'b0;
    #1;
    check("t3_req0",  32'(imem_req), 32'd1);
    check("t3_addr0", imem_addr, 32'h0000_0200);
    step();
    stall = 1'b1;
    #1;
    check("t3_req1",  32'(imem_req), 32'd1);
    check("t3_addr1", imem_addr, 32'h0000_0200);
    step();
    stall = 1'b0;
    #1;
    check("t3_addr2", imem_addr, 32'h0000_0200);
    step();
    stall = 1'b1; imem_ack = 1'b1;
    #1;
    check("t3_req3",  32'(imem_req), 32'd1);
    check("t3_addr3", imem_addr, 32'h0000_0200);
    step();
    check("t3_valid", 32'(if_valid), 32'd1);
    check("t3_pc",    if_pc, 32'h0000_0200);
    check("t3_instr", if_instr, 32'hDEAD_0200);

    // T4: redirect while BUSY kills the pending 0x204 fetch
    stall = 1'b0; imem_ack = 1'b0;
    #1;
    check("t4_req",  32'(imem_req), 32'd1);
    check("t4_addr", imem_addr, 32'h0000_0204);
    step();
    check("t4_busy_valid", 32'(if_valid), 32'd0);
    branch_taken = 1'b1; branch_target = 32'h0000_0040;
    step();
    branch_taken = 1'b0;
    #1;
    check("t4_kill_req",  32'(imem_req), 32'd1);
    check("t4_kill_addr", imem_addr, 32'h0000_0204);
    imem_ack = 1'b1;
    step();
    check("t4_discard", 32'(if_valid), 32'd0);
    check("t4_addr40",  imem_addr, 32'h0000_0040);
    step();
    check("t4_pc",    if_pc, 32'h0000_0040);
    check("t4_instr", if_instr, 32'hDEAD_0040);

    // T5: redirect and stall together, unaligned target
    if_ready = 1'b0; stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0083;
    #1;
    check("t5_req_stall", 32'(imem_req), 32'd0);
    step();
    check("t5_flush", 32'(if_valid), 32'd0);
    branch_taken = 1'b0;
    #1;
    check("t5_addr",   imem_addr, 32'h0000_0080);
    check("t5_no_req", 32'(imem_req), 32'd0);
    step();
    check("t5_still_no_req", 32'(imem_req), 32'd0);
    stall = 1'b0; if_ready = 1'b1;
    #1;
    check("t5_req", 32'(imem_req), 32'd1);
    step();
    check("t5_pc",    if_pc, 32'h0000_0080);
    check("t5_instr", if_instr, 32'hDEAD_0080);

    // T6: wrap at top of address space
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFE;
    step();
    branch_taken = 1'b0;
    #1;
    check("t6_addr_top", imem_addr, 32'hFFFF_FFFC);
    step();
    check("t6_pc_top",    if_pc, 32'hFFFF_FFFC);
    check("t6_instr_top", if_instr, 32'h2152_FFFC);
    check("t6_wrap_addr", imem_addr, 32'h0000_0000);
    step();
    check("t6_wrap_pc", if_pc, 32'h0000_0000);

    // T6: reset mid-BUSY, then redirect in IDLE is ignored
    imem_ack = 1'b0;
    step();
    check("t6_busy_req",  32'(imem_req), 32'd1);
    check("t6_busy_addr", imem_addr, 32'h0000_0004);
    rst_n = 1'b0;
    step();
    check("t6_rst_req",   32'(imem_req), 32'd0);
    check("t6_rst_valid", 32'(if_valid), 32'd0);
    check("t6_rst_addr",  imem_addr, 32'h0000_0100);
    rst_n = 1'b1; imem_ack = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0300;
    step();
    branch_taken = 1'b0;
    #1;
    check("t6_idle_redirect", imem_addr, 32'h0000_0100);
    step();
    check("t6_restart_pc",    if_pc, 32'h0000_0100);
    check("t6_restart_valid", 32'(if_valid), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
